mem_bus_test: RTL and testbench

- Parametrised successor to the fixed 20-bit/8-bit SRAM address-bus self-test.
- Runs one or both of two tests through the SRAM controller command interface (mem/rw/ready), then reports pass/fail with diagnostics:
  - data-bus walking-ones test;
  - address-bus unique-tag test.
- Adds a ready-handshake timeout.
- Sits between the top-level test sequencer and the SRAM controller.

---
 rtl/mem_bus_test.sv | 137 +++++++++++++
 tb/tb_mem_bus_test.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_test.sv
// mem_bus_test: SRAM data-bus walking-ones and address-bus unique-tag self-test
// driven through the mem/rw/ready controller handshake, with a per-transaction ready timeout.
module mem_bus_test #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 8,
    parameter int TEST_ADDR = 0,
    parameter int TIMEOUT   = 64,
    localparam int IDX_W    = $clog2((ADDR_W + 1) > DATA_W ? (ADDR_W + 1) : DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic              mem,
    output logic              rw,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data2ram,
    input  logic [DATA_W-1:0] data2fpga,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic [1:0]        fail_phase,
    output logic [IDX_W-1:0]  fail_idx
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, DATA, ADDR, FINISH} top_t;
    typedef enum logic [1:0] {ISSUE, WAIT_LO, WAIT_HI, CHECK} xact_t;
    top_t              state;
    xact_t             xs;
    logic [IDX_W-1:0]  idx;
    logic              rd;
    logic              do_addr;
    logic [TW-1:0]     tmo;
    logic [DATA_W-1:0] rdata;
    logic              in_data;
    logic              last;
    logic              waiting;
    logic              ok;
    logic              bad;
    logic              tmo_bad;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_data;
    // data2ram always carries the expected pattern, so a read compares against it directly
    always_comb begin
        in_data = state == DATA;
        last    = in_data ? idx == IDX_W'(DATA_W - 1) : idx == IDX_W'(ADDR_W);
        x_addr  = in_data ? ADDR_W'(TEST_ADDR) : (idx == '0 ? '0 : ADDR_W'(1) << (idx - 1'b1));
        x_data  = in_data ? DATA_W'(1) << idx : DATA_W'(idx);
        waiting = (xs == WAIT_LO && ready) || (xs == WAIT_HI && !ready);
        ok      = (xs == WAIT_HI && ready && !rw) || (xs == CHECK && rdata == data2ram);
        bad     = xs == CHECK && rdata != data2ram;
        tmo_bad = waiting && tmo == TW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            xs         <= ISSUE;
            idx        <= '0;
            rd         <= 1'b0;
            do_addr    <= 1'b0;
            tmo        <= '0;
            rdata      <= '0;
            mem        <= 1'b0;
            rw         <= 1'b0;
            addr       <= '0;
            data2ram   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 1'b0;
            fail_phase <= 2'd0;
            fail_idx   <= '0;
        end else begin
            mem  <= 1'b0;
            done <= 1'b0;
            if (state == IDLE) begin
                if (en) begin
                    state      <= mode == 2'd0 ? ADDR : DATA;
                    do_addr    <= mode != 2'd1;
                    xs         <= ISSUE;
                    idx        <= '0;
                    rd         <= 1'b0;
                    busy       <= 1'b1;
                    result     <= 1'b0;
                    fail_phase <= 2'd0;
                    fail_idx   <= '0;
                end
            end else if (state == FINISH) begin
                state <= IDLE;
            end else begin
                if (xs == ISSUE && ready) begin
                    mem      <= 1'b1;
                    rw       <= rd;
                    addr     <= x_addr;
                    data2ram <= x_data;
                    tmo      <= '0;
                    xs       <= WAIT_LO;
                end
                if (xs == WAIT_LO && !ready) xs <= WAIT_HI;
                if (xs == WAIT_HI && ready) begin
                    xs    <= CHECK;
                    rdata <= data2fpga;
                end
                if (xs == WAIT_LO || xs == WAIT_HI) tmo <= tmo + 1'b1;
                // step sequencing: data test pairs write/read per bit, address test does a write pass then a read pass
                if (ok) begin
                    xs <= ISSUE;
                    if (in_data && !rd) begin
                        rd <= 1'b1;
                    end else if (!last) begin
                        idx <= idx + 1'b1;
                        if (in_data) rd <= 1'b0;
                    end else if (!in_data && !rd) begin
                        rd  <= 1'b1;
                        idx <= '0;
                    end else if (in_data && do_addr) begin
                        state <= ADDR;
                        rd    <= 1'b0;
                        idx   <= '0;
                    end else begin
                        state  <= FINISH;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= 1'b1;
                    end
                end
                if (bad || tmo_bad) begin
                    state      <= FINISH;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    fail_phase <= bad ? (in_data ? 2'd2 : 2'd1) : 2'd3;
                    fail_idx   <= idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_test.sv
// tb_mem_bus_test: randomized SRAM responder with injectable faults, checked against
// a sequence-level reference model of the expected command stream and final verdict.
module tb_mem_bus_test;
    localparam int AW  = 20;
    localparam int DW  = 8;
    localparam int TA  = 0;
    localparam int TMO = 64;
    localparam int IW  = 5;
    typedef struct packed {logic rd; logic [AW-1:0] a; logic [DW-1:0] d;} txn_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          ready;
    logic          mem;
    logic          rw;
    logic          busy;
    logic          done;
    logic          result;
    logic [1:0]    fail_phase;
    logic [AW-1:0] addr;
    logic [DW-1:0] data2ram;
    logic [DW-1:0] data2fpga;
    logic [IW-1:0] fail_idx;
    mem_bus_test #(.ADDR_W(AW), .DATA_W(DW), .TEST_ADDR(TA), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .mem(mem), .rw(rw), .ready(ready),
        .addr(addr), .data2ram(data2ram), .data2fpga(data2fpga), .busy(busy), .done(done),
        .result(result), .fail_phase(fail_phase), .fail_idx(fail_idx)
    );
    always #5 clk = ~clk;
    bit            al_on;
    int            al_hi;
    int            al_lo;
    logic [DW-1:0] dmask;
    int            stuck_k;
    int            stuck_abs = -1;
    int            resp_n = 0;
    logic [DW-1:0] sram [logic [AW-1:0]];
    logic          r_w;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    function automatic logic [AW-1:0] eff(input logic [AW-1:0] a);
        return (al_on && a[al_hi]) ? ((a & ~(AW'(1) << al_hi)) | (AW'(1) << al_lo)) : a;
    endfunction
    // SRAM controller: random handshake latency; faults are read-side address aliasing, a stuck-low data bit, or a hung ready
    initial begin
        ready = 1'b1;
        data2fpga = '0;
        forever begin
            @(posedge clk); #1;
            if (mem) begin
                resp_n++;
                if (resp_n != stuck_abs) begin
                    r_w = rw;
                    r_a = addr;
                    r_d = data2ram;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    ready = 1'b0;
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    if (r_w) data2fpga = sram.exists(eff(r_a)) ? sram[eff(r_a)] & dmask : '0;
                    else sram[r_a] = r_d & dmask;
                    ready = 1'b1;
                end
            end
        end
    end
    txn_t          exp_q[$];
    txn_t          obs[$];
    logic [DW-1:0] ref_m [logic [AW-1:0]];
    int            e_n;
    int            e_ph;
    int            e_idx;
    int            checks = 0;
    int            errors = 0;
    int            seen;
    int            dn;
    int            since;
    int            gap;
    logic          r_res;
    logic [1:0]    r_ph;
    logic [IW-1:0] r_idx;
    bit            running;
    int            kind;
    int            s0;
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    function automatic bit xact(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int idx, input int ph);
        logic [DW-1:0] v;
        exp_q.push_back({w, a, d});
        e_n++;
        if (e_n == stuck_k) begin
            e_ph = 3;
            e_idx = idx;
            return 1'b1;
        end
        if (!w) begin
            ref_m[a] = d & dmask;
            return 1'b0;
        end
        v = ref_m.exists(eff(a)) ? ref_m[eff(a)] : '0;
        if (v != d) begin
            e_ph = ph;
            e_idx = idx;
            return 1'b1;
        end
        return 1'b0;
    endfunction
    function automatic void build(input int md);
        bit ab = 1'b0;
        exp_q.delete();
        ref_m.delete();
        e_n = 0;
        e_ph = 0;
        e_idx = 0;
        if (md != 0)
            for (int i = 0; i < DW && !ab; i++) begin
                ab = xact(1'b0, AW'(TA), DW'(1) << i, i, 2);
                if (!ab) ab = xact(1'b1, AW'(TA), DW'(1) << i, i, 2);
            end
        for (int p = 0; p < 2 && md != 1 && !ab; p++)
            for (int k = 0; k <= AW && !ab; k++)
                ab = xact(p[0], k == 0 ? '0 : AW'(1) << (k - 1), DW'(k), k, 1);
    endfunction
    task automatic step();
        txn_t t;
        @(posedge clk); #1;
        since++;
        if (mem) begin
            since = 0;
            seen++;
            obs.push_back({rw, addr, data2ram});
            chk("mem_busy", busy, 1);
            chk("mem_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                chk("mem_rw", rw, t.rd);
                chk("mem_addr", addr, t.a);
                if (!t.rd) chk("mem_wdata", data2ram, t.d);
            end
        end
        if (running) chk("busy", busy, !done);
        if (done) begin
            dn++;
            gap = since;
            r_res = result;
            r_ph = fail_phase;
            r_idx = fail_idx;
        end
    endtask
    task automatic run(input int md, input int poke);
        build(md);
        stuck_abs = stuck_k > 0 ? resp_n + stuck_k : -1;
        seen = 0;
        dn = 0;
        since = 0;
        obs.delete();
        mode = 2'(md);
        en = 1'b1;
        step();
        en = 1'b0;
        chk("busy_start", busy, 1);
        running = 1'b1;
        for (int k = 0; k < 4000 && dn == 0; k++) begin
            if (k == poke) begin
                en = 1'b1;
                mode = 2'($urandom);
            end
            step();
            en = 1'b0;
        end
        running = 1'b0;
        chk("done_seen", dn, 1);
        chk("result", r_res, e_ph == 0);
        chk("fail_phase", r_ph, e_ph);
        chk("fail_idx", r_idx, e_idx);
        chk("mem_count", seen, e_n);
        if (e_ph == 3) chk("timeout_gap", gap, TMO);
        step();
        step();
        chk("done_once", dn, 1);
        chk("result_hold", result, e_ph == 0);
        chk("busy_idle", busy, 0);
        stuck_abs = -1;
    endtask
    initial begin
        al_on = 1'b0;
        al_hi = 0;
        al_lo = 0;
        dmask = '1;
        stuck_k = 0;
        running = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {mem, rw, addr, data2ram, busy, done, result, fail_phase, fail_idx}, '0);
        rst = 1'b0;
        run(0, -1);
        chk("lit_pulses_a", seen, 42);
        chk("lit_w0", obs[0], {1'b0, 20'h0, 8'h00});
        chk("lit_w2_addr", obs[2].a, 20'h2);
        chk("lit_w3_addr", obs[3].a, 20'h4);
        chk("lit_w20", obs[20], {1'b0, 20'h80000, 8'd20});
        chk("lit_r0", obs[21], {1'b1, 20'h0, 8'h00});
        chk("lit_res_a", r_res, 1);
        run(1, -1);
        chk("lit_pulses_d", seen, 16);
        chk("lit_d_r0", obs[1], {1'b1, 20'h0, 8'h01});
        chk("lit_d_w7", obs[14], {1'b0, 20'h0, 8'h80});
        chk("lit_res_d", r_res, 1);
        al_on = 1'b1;
        al_hi = 5;
        al_lo = 4;
        run(0, -1);
        chk("lit_alias_phase", r_ph, 1);
        chk("lit_alias_idx", r_idx, 6);
        chk("lit_alias_res", r_res, 0);
        al_on = 1'b0;
        dmask = ~8'h08;
        run(2, -1);
        chk("lit_stuck_phase", r_ph, 2);
        chk("lit_stuck_idx", r_idx, 3);
        chk("lit_stuck_pulses", seen, 8);
        dmask = '1;
        stuck_k = 3;
        run(0, -1);
        chk("lit_tmo_phase", r_ph, 3);
        chk("lit_tmo_idx", r_idx, 2);
        chk("lit_tmo_gap", gap, 64);
        chk("lit_tmo_res", r_res, 0);
        stuck_k = 0;
        build(0);
        seen = 0;
        mode = 2'd0;
        en = 1'b1;
        step();
        en = 1'b0;
        for (int k = 0; k < 2000 && seen < 10; k++) step();
        chk("rst_reached", seen, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outputs", {mem, rw, addr, data2ram, busy, done, result, fail_phase, fail_idx}, '0);
        exp_q.delete();
        s0 = seen;
        repeat (20) step();
        chk("rst_no_mem", seen, s0);
        run(0, 7);
        chk("rst_rerun_res", r_res, 1);
        for (int r = 0; r < 24; r++) begin
            kind = $urandom_range(0, 3);
            al_on = kind == 1;
            al_hi = $urandom_range(1, AW - 1);
            al_lo = $urandom_range(0, al_hi - 1);
            dmask = kind == 2 ? ~(DW'(1) << $urandom_range(0, DW - 1)) : '1;
            stuck_k = kind == 3 ? $urandom_range(1, 45) : 0;
            run($urandom_range(0, 3), $urandom_range(0, 60));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
